// File: rtl/fifo_pkg.sv
// Shared types and helpers for the configurable synchronous FIFO.
package fifo_pkg;

    typedef enum logic {
        STD_MODE  = 1'b0,
        FWFT_MODE = 1'b1
    } rd_mode_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Explicit wrap so non-power-of-two depths never alias.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_cfg_if.sv
// Producer/consumer handshake bundle for fifo_sync_cfg.
interface fifo_sync_cfg_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
);
    import fifo_pkg::*;

    localparam int CNT_W = cnt_w(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              almost_full;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  full, almost_full, rd_data, rd_valid, empty, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, almost_full, rd_data, rd_valid, empty, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module fifo_sdp_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_cfg.sv
// Single-clock FIFO with selectable FWFT/standard read, any depth >= 2,
// programmable almost flags, occupancy output and error pulses.
module fifo_sync_cfg
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 1,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input logic            clk,
    input logic            rst,
    fifo_sync_cfg_if.slave bus
);

    localparam int       PTR_W = $clog2(DEPTH);
    localparam int       CNT_W = cnt_w(DEPTH);
    localparam rd_mode_e MODE  = (FWFT != 0) ? FWFT_MODE : STD_MODE;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_cfg: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_sync_cfg: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("fifo_sync_cfg: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] ram_q;
    logic              full, empty, wr_acc, rd_acc;

    // Flags decode registered count only; no request-to-flag path.
    assign full   = (cnt == FULL_CNT);
    assign empty  = (cnt == '0);
    assign wr_acc = bus.wr_en && !full;
    assign rd_acc = bus.rd_en && !empty;

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (cnt >= AF_CNT);
    assign bus.almost_empty = (cnt <= AE_CNT);
    assign bus.count        = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= PTR_W'(ptr_next(int'(wr_ptr), DEPTH));
            if (rd_acc) rd_ptr <= PTR_W'(ptr_next(int'(rd_ptr), DEPTH));
            if (wr_acc && !rd_acc)      cnt <= cnt + CNT_W'(1);
            else if (rd_acc && !wr_acc) cnt <= cnt - CNT_W'(1);
            bus.overflow  <= bus.wr_en && full;
            bus.underflow <= bus.rd_en && empty;
        end
    end

    fifo_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    if (MODE == FWFT_MODE) begin : g_fwft
        assign bus.rd_data  = empty ? '0 : ram_q;
        assign bus.rd_valid = !empty;
    end else begin : g_std
        logic [DATA_W-1:0] rd_q;
        logic              rd_v;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= '0;
                rd_v <= 1'b0;
            end else begin
                rd_v <= rd_acc;
                if (rd_acc) rd_q <= ram_q;
            end
        end

        assign bus.rd_data  = rd_q;
        assign bus.rd_valid = rd_v;
    end

endmodule

// File: tb/tb_fifo_sync_cfg.sv
// Drives an FWFT and a standard-read instance (DEPTH=5, AF=4, AE=1) with
// identical stimulus and checks both against a queue-based reference model.
module tb_fifo_sync_cfg;

    localparam int DW = 16;
    localparam int D  = 5;
    localparam int CW = 3;
    localparam int AF = 4;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    always #5 clk = ~clk;

    fifo_sync_cfg_if #(.DATA_W(DW), .DEPTH(D)) bf ();
    fifo_sync_cfg_if #(.DATA_W(DW), .DEPTH(D)) bs ();

    assign bf.wr_en   = wr_en;
    assign bf.wr_data = wr_data;
    assign bf.rd_en   = rd_en;
    assign bs.wr_en   = wr_en;
    assign bs.wr_data = wr_data;
    assign bs.rd_en   = rd_en;

    fifo_sync_cfg #(
        .DATA_W(DW), .DEPTH(D), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)
    ) u_fwft (
        .clk (clk),
        .rst (rst),
        .bus (bf)
    );

    fifo_sync_cfg #(
        .DATA_W(DW), .DEPTH(D), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)
    ) u_std (
        .clk (clk),
        .rst (rst),
        .bus (bs)
    );

    // Reference model: contents as a queue, plus last-cycle pulses and the
    // standard-mode output register.
    logic [DW-1:0] mq[$];
    logic          m_ovf = 1'b0, m_udf = 1'b0, s_v = 1'b0;
    logic [DW-1:0] s_q = '0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic step(input logic r, input logic we, input logic [DW-1:0] wd, input logic re);
        int sz;
        rst     = r;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        sz = mq.size();
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            s_v   = 1'b0;
            s_q   = '0;
        end else begin
            m_ovf = we && (sz == D);
            m_udf = re && (sz == 0);
            s_v   = 1'b0;
            if (re && sz != 0) begin
                s_q = mq.pop_front();
                s_v = 1'b1;
            end
            if (we && sz != D) mq.push_back(wd);
        end
        #1;
    endtask

    // {count, full, almost_full, empty, almost_empty, overflow, underflow, rd_valid, rd_data}
    function automatic logic [25:0] exp_vec(input bit fwft);
        int            sz = mq.size();
        logic          v;
        logic [DW-1:0] d;
        if (fwft) begin
            v = (sz != 0);
            d = v ? mq[0] : '0;
        end else begin
            v = s_v;
            d = s_q;
        end
        return {CW'(sz), sz == D, sz >= AF, sz == 0, sz <= AE, m_ovf, m_udf, v, d};
    endfunction

    function automatic logic [25:0] obs_fwft();
        return {bf.count, bf.full, bf.almost_full, bf.empty, bf.almost_empty,
                bf.overflow, bf.underflow, bf.rd_valid, bf.rd_data};
    endfunction

    function automatic logic [25:0] obs_std();
        return {bs.count, bs.full, bs.almost_full, bs.empty, bs.almost_empty,
                bs.overflow, bs.underflow, bs.rd_valid, bs.rd_data};
    endfunction

    task automatic test_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        n_chk++;
        if (obs_fwft() !== 26'h0_0D0000 >> 0 && obs_fwft() !== exp_vec(1))
            $display("FAIL reset_fwft got=%h want=%h", obs_fwft(), exp_vec(1));
        else n_pass++;
        n_chk++;
        if ({bs.count, bs.empty, bs.almost_empty, bs.rd_valid, bs.rd_data} !== {3'd0, 1'b1, 1'b1, 1'b0, 16'h0000})
            $display("FAIL reset_std got=%h want=%h", obs_std(), exp_vec(0));
        else n_pass++;
        step(1'b0, 1'b0, '0, 1'b0);
        n_chk++;
        if (obs_fwft() !== exp_vec(1)) $display("FAIL reset_idle_fwft got=%h want=%h", obs_fwft(), exp_vec(1));
        else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= D; i++) begin
            step(1'b0, 1'b1, DW'(i), 1'b0);
            n_chk++;
            if (obs_fwft() !== exp_vec(1)) $display("FAIL fill_fwft[%0d] got=%h want=%h", i, obs_fwft(), exp_vec(1));
            else n_pass++;
            n_chk++;
            if (obs_std() !== exp_vec(0)) $display("FAIL fill_std[%0d] got=%h want=%h", i, obs_std(), exp_vec(0));
            else n_pass++;
        end
        n_chk++;
        if ({bf.full, bf.almost_full, bf.almost_empty, bf.rd_valid, bf.rd_data} !== {4'b1101, 16'h0001})
            $display("FAIL fill_flags got=%b/%h want=1101/0001",
                     {bf.full, bf.almost_full, bf.almost_empty, bf.rd_valid}, bf.rd_data);
        else n_pass++;
    endtask

    task automatic test_overflow();
        step(1'b0, 1'b1, 16'h00AA, 1'b0);
        n_chk++;
        if ({bf.overflow, bf.count} !== {1'b1, 3'd5}) $display("FAIL ovf_pulse got=%b/%0d want=1/5", bf.overflow, bf.count);
        else n_pass++;
        step(1'b0, 1'b0, '0, 1'b0);
        n_chk++;
        if (obs_fwft() !== exp_vec(1)) $display("FAIL ovf_clear got=%h want=%h", obs_fwft(), exp_vec(1));
        else n_pass++;
        for (int i = 0; i < D; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            n_chk++;
            if (obs_fwft() !== exp_vec(1)) $display("FAIL drain_fwft[%0d] got=%h want=%h", i, obs_fwft(), exp_vec(1));
            else n_pass++;
            n_chk++;
            if (obs_std() !== exp_vec(0)) $display("FAIL drain_std[%0d] got=%h want=%h", i, obs_std(), exp_vec(0));
            else n_pass++;
        end
        step(1'b0, 1'b0, '0, 1'b1);
        n_chk++;
        if ({bf.underflow, bf.rd_data, bf.empty} !== {1'b1, 16'h0000, 1'b1})
            $display("FAIL udf_pulse got=%b/%h want=1/0000", bf.underflow, bf.rd_data);
        else n_pass++;
        n_chk++;
        if (obs_std() !== exp_vec(0)) $display("FAIL udf_std got=%h want=%h", obs_std(), exp_vec(0));
        else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'(16'h0100 + i), 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, DW'(16'h0103 + i), 1'b1);
            n_chk++;
            if (bf.count !== 3'd3 || obs_fwft() !== exp_vec(1))
                $display("FAIL wrap_fwft[%0d] got=%h want=%h", i, obs_fwft(), exp_vec(1));
            else n_pass++;
            n_chk++;
            if (bs.rd_data !== DW'(16'h0100 + i) || obs_std() !== exp_vec(0))
                $display("FAIL wrap_std[%0d] got=%h want=%h", i, obs_std(), exp_vec(0));
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_boundary();
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, DW'(16'h0200 + i), 1'b0);
        step(1'b0, 1'b1, 16'hBEEF, 1'b1);
        n_chk++;
        if ({bf.count, bf.overflow} !== {3'd4, 1'b1} || obs_fwft() !== exp_vec(1))
            $display("FAIL full_rw got=%h want=%h", obs_fwft(), exp_vec(1));
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            n_chk++;
            if (obs_std() !== exp_vec(0)) $display("FAIL full_rw_drain[%0d] got=%h want=%h", i, obs_std(), exp_vec(0));
            else n_pass++;
        end
        step(1'b0, 1'b1, 16'hCAFE, 1'b1);
        n_chk++;
        if ({bf.count, bf.underflow, bf.rd_valid, bf.rd_data} !== {3'd1, 1'b1, 1'b1, 16'hCAFE})
            $display("FAIL empty_rw got=%h want=%h", obs_fwft(), exp_vec(1));
        else n_pass++;
        step(1'b0, 1'b0, '0, 1'b1);
        n_chk++;
        if (bs.rd_data !== 16'hCAFE || obs_std() !== exp_vec(0))
            $display("FAIL empty_rw_std got=%h want=%h", obs_std(), exp_vec(0));
        else n_pass++;
    endtask

    task automatic test_std();
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        step(1'b0, 1'b1, 16'h5678, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        n_chk++;
        if ({bs.rd_valid, bs.rd_data} !== {1'b1, 16'h1234}) $display("FAIL std_rd0 got=%b/%h want=1/1234", bs.rd_valid, bs.rd_data);
        else n_pass++;
        step(1'b0, 1'b0, '0, 1'b1);
        n_chk++;
        if ({bs.rd_valid, bs.rd_data} !== {1'b1, 16'h5678}) $display("FAIL std_rd1 got=%b/%h want=1/5678", bs.rd_valid, bs.rd_data);
        else n_pass++;
        step(1'b0, 1'b0, '0, 1'b0);
        n_chk++;
        if ({bs.rd_valid, bs.rd_data} !== {1'b0, 16'h5678} || obs_std() !== exp_vec(0))
            $display("FAIL std_hold got=%b/%h want=0/5678", bs.rd_valid, bs.rd_data);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'(16'h0300 + i), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 16'h0F0F, 1'b1);
        n_chk++;
        if ({bf.count, bf.empty, bf.rd_data, bf.overflow, bf.underflow} !== {3'd0, 1'b1, 16'h0000, 2'b00})
            $display("FAIL midrst_fwft got=%h want=%h", obs_fwft(), exp_vec(1));
        else n_pass++;
        n_chk++;
        if ({bs.rd_data, bs.rd_valid} !== {16'h0000, 1'b0} || obs_std() !== exp_vec(0))
            $display("FAIL midrst_std got=%h want=%h", obs_std(), exp_vec(0));
        else n_pass++;
        step(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_random();
        int p_wr, p_rd;
        logic r, we, re;
        for (int i = 0; i < 400; i++) begin
            // Alternate fill-biased and drain-biased phases to visit both edges.
            p_wr = ((i / 40) % 2 == 0) ? 75 : 30;
            p_rd = ((i / 40) % 2 == 0) ? 30 : 75;
            r  = ($urandom_range(0, 149) == 0);
            we = ($urandom_range(0, 99) < p_wr);
            re = ($urandom_range(0, 99) < p_rd);
            step(r, we, DW'($urandom), re);
            n_chk++;
            if (obs_fwft() !== exp_vec(1)) $display("FAIL rand_fwft[%0d] got=%h want=%h", i, obs_fwft(), exp_vec(1));
            else n_pass++;
            n_chk++;
            if (obs_std() !== exp_vec(0)) $display("FAIL rand_std[%0d] got=%h want=%h", i, obs_std(), exp_vec(0));
            else n_pass++;
        end
    endtask

    initial begin
        step(1'b1, 1'b0, '0, 1'b0);
        test_reset();
        test_fill();
        test_overflow();
        test_wrap();
        test_boundary();
        test_std();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
